// File: rtl/bank_access_ctrl_if.sv
// Request, read-return and bank-pin bundle for bank_access_ctrl; master = client/bank side, slave = controller.
// Purely wiring: no latency, no flow control of its own.
interface bank_access_ctrl_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 8
);
    logic              wr_valid;
    logic              wr_ready;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              rd_req_valid;
    logic              rd_req_ready;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_data_valid;
    logic              rd_data_ready;
    logic [DATA_W-1:0] rd_data;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_din;
    logic [DATA_W-1:0] mem_dout;
    logic              busy;

    modport master (
        output wr_valid, wr_addr, wr_data, rd_req_valid, rd_addr, rd_data_ready, mem_dout,
        input  wr_ready, rd_req_ready, rd_data_valid, rd_data, mem_we, mem_addr, mem_din, busy
    );

    modport slave (
        input  wr_valid, wr_addr, wr_data, rd_req_valid, rd_addr, rd_data_ready, mem_dout,
        output wr_ready, rd_req_ready, rd_data_valid, rd_data, mem_we, mem_addr, mem_din, busy
    );
endinterface

// File: rtl/bank_access_ctrl.sv
// Single-port bank front-end: fair write/read arbitration, 2-cycle read return through an OUT_DEPTH FIFO.
// Reads are only accepted while FIFO occupancy plus in-flight read leaves room, so rd_data_ready backpressure never drops data.
module bank_access_ctrl #(
    parameter int DATA_W    = 16,
    parameter int ADDR_W    = 8,
    parameter int OUT_DEPTH = 4
) (
    input logic               clk,
    input logic               rst_n,
    bank_access_ctrl_if.slave bus
);
    localparam int                CNT_W     = $clog2(OUT_DEPTH + 1);
    localparam logic [CNT_W-1:0]  LAST_IDX  = CNT_W'(OUT_DEPTH - 1);
    localparam logic [CNT_W-1:0]  DEPTH_CNT = CNT_W'(OUT_DEPTH);
    localparam logic [CNT_W:0]    DEPTH_EXT = (CNT_W + 1)'(OUT_DEPTH);

    typedef enum logic {
        GRANT_WR = 1'b0,
        GRANT_RD = 1'b1
    } grant_e;

    grant_e            r_last_grant;
    logic              r_inflight;
    logic [CNT_W-1:0]  r_count;
    logic [CNT_W-1:0]  r_wr_ptr;
    logic [CNT_W-1:0]  r_rd_ptr;
    logic [DATA_W-1:0] r_fifo [OUT_DEPTH];

    logic              w_rd_ok;
    logic              w_rd_elig;
    logic              w_wr_req;
    logic              w_do_wr;
    logic              w_do_rd;
    logic              w_push;
    logic              w_pop;
    logic [DATA_W-1:0] w_head;

    // Credit uses registered state only: a pop this cycle frees a slot next cycle.
    assign w_rd_ok   = ({1'b0, r_count} + (CNT_W + 1)'(r_inflight)) < DEPTH_EXT;
    assign w_rd_elig = rst_n && bus.rd_req_valid && w_rd_ok;
    assign w_wr_req  = rst_n && bus.wr_valid;

    always_comb begin
        w_do_wr = w_wr_req  && (!w_rd_elig || (r_last_grant == GRANT_RD));
        w_do_rd = w_rd_elig && (!w_wr_req  || (r_last_grant == GRANT_WR));
    end

    assign bus.wr_ready     = w_do_wr;
    assign bus.rd_req_ready = w_do_rd;
    assign bus.mem_we       = w_do_wr;
    assign bus.mem_addr     = w_do_wr ? bus.wr_addr : (w_do_rd ? bus.rd_addr : '0);
    assign bus.mem_din      = w_do_wr ? bus.wr_data : '0;

    assign w_push = r_inflight;
    assign w_pop  = bus.rd_data_valid && bus.rd_data_ready;

    always_comb begin
        w_head = '0;
        for (int i = 0; i < OUT_DEPTH; i++) begin
            if (r_rd_ptr == CNT_W'(i)) w_head = r_fifo[i];
        end
    end

    assign bus.rd_data_valid = (r_count != '0);
    assign bus.rd_data       = w_head;
    assign bus.busy          = r_inflight || (r_count != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_grant <= GRANT_RD;
            r_inflight   <= 1'b0;
            r_count      <= '0;
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            for (int i = 0; i < OUT_DEPTH; i++) r_fifo[i] <= '0;
        end else begin
            if (w_do_wr)      r_last_grant <= GRANT_WR;
            else if (w_do_rd) r_last_grant <= GRANT_RD;

            r_inflight <= w_do_rd;

            // Bank dout is valid exactly one cycle after the read was issued.
            if (w_push) begin
                for (int i = 0; i < OUT_DEPTH; i++) begin
                    if (r_wr_ptr == CNT_W'(i)) r_fifo[i] <= bus.mem_dout;
                end
                r_wr_ptr <= (r_wr_ptr == LAST_IDX) ? '0 : r_wr_ptr + CNT_W'(1);
            end

            if (w_pop) r_rd_ptr <= (r_rd_ptr == LAST_IDX) ? '0 : r_rd_ptr + CNT_W'(1);

            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(w_push && (r_count == DEPTH_CNT)));
endmodule

// File: tb/tb_bank_access_ctrl.sv
// Directed bench for bank_access_ctrl: depth-4 instance for the main scenarios, depth-3 instance for pointer wrap.
module tb_bank_access_ctrl;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    bank_access_ctrl_if #(.DATA_W(16), .ADDR_W(8)) bA ();
    bank_access_ctrl_if #(.DATA_W(16), .ADDR_W(8)) bB ();

    bank_access_ctrl #(.DATA_W(16), .ADDR_W(8), .OUT_DEPTH(4)) u_dut_a (.clk(clk), .rst_n(rst_n), .bus(bA));
    bank_access_ctrl #(.DATA_W(16), .ADDR_W(8), .OUT_DEPTH(3)) u_dut_b (.clk(clk), .rst_n(rst_n), .bus(bB));

    // Bank models: write at posedge, registered read with one cycle latency.
    logic [15:0] mem_a [256];
    logic [15:0] mem_b [256];
    always @(posedge clk) begin
        if (bA.mem_we) mem_a[bA.mem_addr] <= bA.mem_din;
        bA.mem_dout <= mem_a[bA.mem_addr];
        if (bB.mem_we) mem_b[bB.mem_addr] <= bB.mem_din;
        bB.mem_dout <= mem_b[bB.mem_addr];
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int a;
    int issued;
    int got;
    int cyc;

    initial begin
        rst_n = 1'b0;
        bA.wr_valid = 1'b1; bA.wr_addr = 8'h55; bA.wr_data = 16'h1234;
        bA.rd_req_valid = 1'b1; bA.rd_addr = 8'h66; bA.rd_data_ready = 1'b0;
        bB.wr_valid = 1'b0; bB.wr_addr = '0; bB.wr_data = '0;
        bB.rd_req_valid = 1'b0; bB.rd_addr = '0; bB.rd_data_ready = 1'b0;

        repeat (2) @(posedge clk);
        #2;
        check("rst_rd_data_valid", 32'(bA.rd_data_valid), 0);
        check("rst_rd_data",       32'(bA.rd_data), 0);
        check("rst_busy",          32'(bA.busy), 0);
        check("rst_mem_we",        32'(bA.mem_we), 0);
        check("rst_mem_addr",      32'(bA.mem_addr), 0);
        check("rst_mem_din",       32'(bA.mem_din), 0);
        check("rst_wr_ready",      32'(bA.wr_ready), 0);
        check("rst_rd_req_ready",  32'(bA.rd_req_ready), 0);
        bA.wr_valid = 1'b0; bA.rd_req_valid = 1'b0;

        // Write/readback
        @(posedge clk); #1;
        rst_n = 1'b1;
        bA.wr_valid = 1'b1; bA.wr_addr = 8'h10; bA.wr_data = 16'hBEEF; bA.rd_data_ready = 1'b1;
        #1;
        check("wb_wr_ready", 32'(bA.wr_ready), 1);
        check("wb_mem_we",   32'(bA.mem_we), 1);
        check("wb_mem_addr", 32'(bA.mem_addr), 32'h10);
        check("wb_mem_din",  32'(bA.mem_din), 32'hBEEF);
        tick();
        bA.wr_valid = 1'b0; bA.rd_req_valid = 1'b1; bA.rd_addr = 8'h10;
        #1;
        check("wb_rd_req_ready", 32'(bA.rd_req_ready), 1);
        check("wb_rd_mem_we",    32'(bA.mem_we), 0);
        check("wb_rd_mem_addr",  32'(bA.mem_addr), 32'h10);
        tick();
        bA.rd_req_valid = 1'b0;
        #1;
        check("wb_c2_valid", 32'(bA.rd_data_valid), 0);
        check("wb_c2_busy",  32'(bA.busy), 1);
        tick(); #1;
        check("wb_c3_valid", 32'(bA.rd_data_valid), 1);
        check("wb_c3_data",  32'(bA.rd_data), 32'hBEEF);
        tick(); #1;
        check("wb_c4_valid", 32'(bA.rd_data_valid), 0);
        check("wb_c4_busy",  32'(bA.busy), 0);

        // Streaming: preload addr*3 then read 0..15 back to back
        for (int i = 0; i < 16; i++) begin
            tick();
            bA.wr_valid = 1'b1; bA.wr_addr = 8'(i); bA.wr_data = 16'(i * 3);
        end
        for (int k = 0; k < 19; k++) begin
            tick();
            bA.wr_valid = 1'b0;
            bA.rd_req_valid = (k < 16);
            bA.rd_addr = 8'(k);
            #1;
            if (k < 16) check("stream_rdy", 32'(bA.rd_req_ready), 1);
            if (k >= 2 && k < 18) begin
                check("stream_valid", 32'(bA.rd_data_valid), 1);
                check("stream_data",  32'(bA.rd_data), 32'((k - 2) * 3));
            end
            if (k == 18) check("stream_end_valid", 32'(bA.rd_data_valid), 0);
        end

        // Backpressure: consumer stalled, requests held
        a = 0;
        for (int c = 0; c < 8; c++) begin
            tick();
            bA.rd_data_ready = 1'b0; bA.rd_req_valid = 1'b1; bA.rd_addr = 8'(a);
            #1;
            if (bA.rd_req_ready) a++;
        end
        check("bp_accepts",   32'(a), 4);
        check("bp_ready_low", 32'(bA.rd_req_ready), 0);
        check("bp_full_valid", 32'(bA.rd_data_valid), 1);
        tick();
        bA.rd_data_ready = 1'b1; bA.rd_addr = 8'(a);
        #1;
        check("bp_no_same_cycle_credit", 32'(bA.rd_req_ready), 0);
        check("bp_drain0", 32'(bA.rd_data), 0);
        tick(); #1;
        check("bp_credit_next_cycle", 32'(bA.rd_req_ready), 1);
        check("bp_drain1", 32'(bA.rd_data), 3);
        for (int j = 2; j < 6; j++) begin
            tick();
            bA.rd_req_valid = 1'b0;
            #1;
            check("bp_drain_valid", 32'(bA.rd_data_valid), 32'(j < 5));
            if (j < 5) check("bp_drain_data", 32'(bA.rd_data), 32'(j * 3));
        end

        // Contention: both valid for 6 cycles, write wins first
        for (int k = 0; k < 8; k++) begin
            tick();
            bA.wr_valid = (k < 6); bA.rd_req_valid = (k < 6);
            bA.wr_addr = 8'(8'h40 + k / 2); bA.wr_data = 16'(16'hA000 + k / 2);
            bA.rd_addr = 8'(8'h40 + k / 2);
            #1;
            if (k < 6) begin
                check("cont_wr_grant", 32'(bA.wr_ready), 32'((k % 2) == 0));
                check("cont_rd_grant", 32'(bA.rd_req_ready), 32'((k % 2) == 1));
            end
            check("cont_valid", 32'(bA.rd_data_valid), 32'((k >= 3) && ((k % 2) == 1)));
            if ((k >= 3) && ((k % 2) == 1)) check("cont_data", 32'(bA.rd_data), 32'(16'hA000 + (k - 3) / 2));
        end

        // Reset mid-operation
        for (int c = 0; c < 4; c++) begin
            tick();
            bA.rd_data_ready = 1'b0; bA.rd_req_valid = (c < 3); bA.rd_addr = 8'(c);
            #1;
            if (c < 3) check("rst_mid_accept", 32'(bA.rd_req_ready), 1);
        end
        #1 rst_n = 1'b0;
        #1;
        check("rst_mid_valid", 32'(bA.rd_data_valid), 0);
        check("rst_mid_busy",  32'(bA.busy), 0);
        tick();
        rst_n = 1'b1; bA.rd_data_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            #1;
            check("rst_no_stale", 32'(bA.rd_data_valid), 0);
            tick();
        end
        bA.rd_req_valid = 1'b1; bA.rd_addr = 8'h10;
        #1;
        check("rst_post_rdy", 32'(bA.rd_req_ready), 1);
        tick();
        bA.rd_req_valid = 1'b0;
        tick(); #1;
        check("rst_persist_valid", 32'(bA.rd_data_valid), 1);
        check("rst_persist_data",  32'(bA.rd_data), 32'hBEEF);

        // Wrap on the depth-3 instance
        for (int i = 0; i < 20; i++) begin
            tick();
            bB.wr_valid = 1'b1; bB.wr_addr = 8'(i); bB.wr_data = 16'(16'h100 + i);
        end
        issued = 0; got = 0; cyc = 0;
        while (got < 20 && cyc < 300) begin
            tick();
            bB.wr_valid = 1'b0;
            bB.rd_data_ready = cyc[1];
            bB.rd_req_valid = (issued < 20);
            bB.rd_addr = 8'(issued);
            #1;
            if (bB.rd_req_valid && bB.rd_req_ready) issued++;
            if (bB.rd_data_valid && bB.rd_data_ready) begin
                check("wrap_data", 32'(bB.rd_data), 32'(16'h100 + got));
                got++;
            end
            cyc++;
        end
        check("wrap_count", 32'(got), 20);
        for (int c = 0; c < 4; c++) begin
            tick();
            bB.rd_data_ready = 1'b1; bB.rd_req_valid = 1'b0;
            #1;
            check("wrap_no_dup", 32'(bB.rd_data_valid), 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
